// File: rtl/up_tpl_bus_arbiter_pkg.sv
// Shared types and constants for the two-master up-bus arbiter.
package up_tpl_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  // Slot index: bit 1 selects the master, bit 0 marks a read.
  localparam logic [1:0] SlotM0W = 2'd0;
  localparam logic [1:0] SlotM0R = 2'd1;
  localparam logic [1:0] SlotM1W = 2'd2;
  localparam logic [1:0] SlotM1R = 2'd3;
  localparam int unsigned NumSlots = 4;

  localparam logic [31:0] DefaultTimeoutRdata = 32'hDEADDEAD;

endpackage

// File: rtl/up_tpl_bus_arbiter_if.sv
// One up-bus register port: write and read request/ack channels.
interface up_tpl_bus_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 14
);
  logic                     wreq;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [31:0]              wdata;
  logic                     wack;
  logic                     rreq;
  logic [ADDRESS_WIDTH-1:0] raddr;
  logic [31:0]              rdata;
  logic                     rack;

  modport master (
    output wreq, waddr, wdata, rreq, raddr,
    input  wack, rdata, rack
  );

  modport slave (
    input  wreq, waddr, wdata, rreq, raddr,
    output wack, rdata, rack
  );
endinterface

// File: rtl/up_tpl_req_slot.sv
// Single pending-request slot: captures address/data on a pulse, holds until cleared.
module up_tpl_req_slot #(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     clear,
  output logic                     pending,
  output logic [ADDRESS_WIDTH-1:0] slot_addr,
  output logic [DATA_WIDTH-1:0]    slot_data
);

  logic                     pending_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  // A pulse on an already-pending slot is dropped so the first request wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (clear) begin
      pending_q <= 1'b0;
    end else if (req && !pending_q) begin
      pending_q <= 1'b1;
      addr_q    <= addr;
      data_q    <= data;
    end
  end

  assign pending   = pending_q;
  assign slot_addr = addr_q;
  assign slot_data = data_q;

endmodule

// File: rtl/up_tpl_bus_arbiter.sv
// Round-robin arbiter sharing one up-bus slave between two masters, with an ack watchdog.
module up_tpl_bus_arbiter
  import up_tpl_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 14,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = DefaultTimeoutRdata
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,
  up_tpl_bus_arbiter_if.slave          m0,
  up_tpl_bus_arbiter_if.slave          m1,
  up_tpl_bus_arbiter_if.master         s,
  output logic                         timeout_pulse,
  output logic [7:0]                   timeout_count
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [NumSlots-1:0]      pend;
  logic [NumSlots-1:0]      clear;
  logic [ADDRESS_WIDTH-1:0] slot_addr [NumSlots];
  logic [31:0]              slot_data [NumSlots];

  up_tpl_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(32)) u_slot_m0w (
    .clk(up_clk), .rst_n(up_rstn), .req(m0.wreq), .addr(m0.waddr), .data(m0.wdata),
    .clear(clear[SlotM0W]), .pending(pend[SlotM0W]),
    .slot_addr(slot_addr[SlotM0W]), .slot_data(slot_data[SlotM0W])
  );

  up_tpl_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(32)) u_slot_m0r (
    .clk(up_clk), .rst_n(up_rstn), .req(m0.rreq), .addr(m0.raddr), .data(32'd0),
    .clear(clear[SlotM0R]), .pending(pend[SlotM0R]),
    .slot_addr(slot_addr[SlotM0R]), .slot_data(slot_data[SlotM0R])
  );

  up_tpl_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(32)) u_slot_m1w (
    .clk(up_clk), .rst_n(up_rstn), .req(m1.wreq), .addr(m1.waddr), .data(m1.wdata),
    .clear(clear[SlotM1W]), .pending(pend[SlotM1W]),
    .slot_addr(slot_addr[SlotM1W]), .slot_data(slot_data[SlotM1W])
  );

  up_tpl_req_slot #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(32)) u_slot_m1r (
    .clk(up_clk), .rst_n(up_rstn), .req(m1.rreq), .addr(m1.raddr), .data(32'd0),
    .clear(clear[SlotM1R]), .pending(pend[SlotM1R]),
    .slot_addr(slot_addr[SlotM1R]), .slot_data(slot_data[SlotM1R])
  );

  arb_state_e               state_q, state_d;
  logic [1:0]               owner_q;
  logic                     rr_q;
  logic [15:0]              wd_cnt_q;
  logic                     timed_out_q;
  logic [7:0]               tcount_q;
  logic [ADDRESS_WIDTH-1:0] s_waddr_q, s_raddr_q;
  logic [31:0]              s_wdata_q;
  logic [31:0]              m_rdata_q [2];

  logic       m0_any, m1_any, any_pend, sel_m;
  logic [1:0] sel_slot;
  logic       grant, slave_ack, expire, in_resp;

  always_comb begin
    m0_any   = pend[SlotM0W] | pend[SlotM0R];
    m1_any   = pend[SlotM1W] | pend[SlotM1R];
    any_pend = m0_any | m1_any;
    sel_m    = (m0_any && m1_any) ? rr_q : m1_any;
    if (sel_m) begin
      sel_slot = pend[SlotM1W] ? SlotM1W : SlotM1R;
    end else begin
      sel_slot = pend[SlotM0W] ? SlotM0W : SlotM0R;
    end
  end

  assign grant = (state_q == StIdle) && any_pend;

  always_comb begin
    state_d   = state_q;
    slave_ack = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      StIdle:  if (any_pend) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        // Only the ack matching the issued type counts; a same-cycle ack beats expiry.
        slave_ack = owner_q[0] ? s.rack : s.wack;
        expire    = !slave_ack && (wd_cnt_q == TimeoutLimit);
        if (slave_ack || expire) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q      <= StIdle;
      owner_q      <= SlotM0W;
      rr_q         <= 1'b0;
      wd_cnt_q     <= '0;
      timed_out_q  <= 1'b0;
      tcount_q     <= '0;
      s_waddr_q    <= '0;
      s_wdata_q    <= '0;
      s_raddr_q    <= '0;
      m_rdata_q[0] <= '0;
      m_rdata_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= (state_q == StWait) ? wd_cnt_q + 16'd1 : 16'd0;
      if (grant) begin
        owner_q <= sel_slot;
        rr_q    <= ~sel_m;
        if (sel_slot[0]) begin
          s_raddr_q <= slot_addr[sel_slot];
        end else begin
          s_waddr_q <= slot_addr[sel_slot];
          s_wdata_q <= slot_data[sel_slot];
        end
      end
      if ((state_q == StWait) && (state_d == StResp)) begin
        timed_out_q <= expire;
        if (expire && (tcount_q != 8'hFF)) tcount_q <= tcount_q + 8'd1;
        if (owner_q[0]) m_rdata_q[owner_q[1]] <= expire ? TIMEOUT_RDATA : s.rdata;
      end
    end
  end

  assign in_resp = (state_q == StResp);
  assign clear   = in_resp ? (4'b0001 << owner_q) : 4'b0000;

  assign s.wreq  = (state_q == StIssue) && !owner_q[0];
  assign s.rreq  = (state_q == StIssue) && owner_q[0];
  assign s.waddr = s_waddr_q;
  assign s.wdata = s_wdata_q;
  assign s.raddr = s_raddr_q;

  assign m0.wack  = clear[SlotM0W];
  assign m0.rack  = clear[SlotM0R];
  assign m0.rdata = m_rdata_q[0];
  assign m1.wack  = clear[SlotM1W];
  assign m1.rack  = clear[SlotM1R];
  assign m1.rdata = m_rdata_q[1];

  assign timeout_pulse = in_resp && timed_out_q;
  assign timeout_count = tcount_q;

endmodule
